imm_operand_stage: RTL
======================

Name: imm_operand_stage

Overview:
- Registered immediate-operand stage directly downstream of zero_ext in the ID→EX path.
- Takes the zero-extended immediate produced by zero_ext, the sign-extended immediate and the raw 16-bit field, and selects the EX operand per ext_op (zero / sign / LUI).
- Forwards the operand with a valid/ready handshake through a 2-entry skid buffer, so EX backpressure never drops or reorders immediates.

Parameters:
- DATA_WIDTH_IN, 16 (mips_pkg): raw immediate width.
- DATA_WIDTH_OUT, 32 (mips_pkg): datapath/operand width.
- REG_ADDR_WIDTH, 5: destination register field width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  decode presents a valid immediate
- in_ready  output  1  stage can accept this cycle
- in_imm  input  DATA_WIDTH_IN  raw instruction[15:0]
- in_zext  input  DATA_WIDTH_OUT  zero_ext data_out for in_imm
- in_sext  input  DATA_WIDTH_OUT  sign-extended in_imm
- in_ext_op  input  2  00 zero, 01 sign, 10 LUI, 11 illegal
- in_rt  input  REG_ADDR_WIDTH  destination register tag
- flush  input  1  squash all held entries (branch/jump)
- out_valid  output  1  out_imm/out_rt valid
- out_ready  input  1  EX accepts this cycle
- out_imm  output  DATA_WIDTH_OUT  selected 32-bit operand
- out_rt  output  REG_ADDR_WIDTH  tag travelling with out_imm
- ext_err  output  1  sticky: illegal ext_op accepted

Behaviour:
- Operand select (combinational, before registering):
  - 00 → in_zext
  - 01 → in_sext
  - 10 → {in_imm, 16'b0}, i.e. in_imm placed in the upper DATA_WIDTH_IN bits with zeros in the lower DATA_WIDTH_OUT-DATA_WIDTH_IN bits
  - 11 → all zeros, and sets ext_err
- Storage: main register (drives outputs) plus one skid register, each entry {valid, imm, rt}.
- Handshake:
  - in_ready = !skid_valid, registered (no combinational path from out_ready).
  - Accept when in_valid && in_ready; pop when out_valid && out_ready.
- Transfers per cycle, evaluated with flush = 0:
  - Main empty, accept → load main.
  - Main full and popped, skid empty, accept → load main.
  - Main full and popped, skid full → skid moves to main; skid empty.
  - Main full and not popped, accept → load skid.
  - Simultaneous pop and accept with skid full cannot occur, because in_ready = 0 then.
- Latency and throughput:
  - Accepted data appears on out_* exactly 1 cycle later when main is empty.
  - Sustained 1 operand/cycle while out_ready = 1.
- Ordering: strict FIFO order; never drops or duplicates an entry.
- Flush:
  - Clears both valid bits at the next edge; any same-cycle input is dropped.
  - out_valid = 0 and in_ready = 1 the following cycle.
  - Data registers may retain stale values.
  - flush has priority over accept and pop.
- Reset:
  - out_valid = 0, out_imm = 0, out_rt = 0, skid cleared, ext_err = 0, in_ready = 0 while rst is high.
  - in_ready = 1 on the first cycle after rst deasserts.
  - Reset mid-stream discards all held entries.
- Output stability: while out_valid && !out_ready, out_imm and out_rt hold stable.
- ext_err: set on acceptance of ext_op 11; cleared only by rst (not by flush).

Test Plan:
- ext_op 00, in_imm 16'hF0F0, in_zext 32'h0000F0F0, out_ready = 1 → next cycle out_valid = 1, out_imm = 32'h0000F0F0.
- ext_op 01 with in_imm 16'h8001 / in_sext 32'hFFFF8001, then ext_op 10 with in_imm 16'h1234, back-to-back → out_imm 32'hFFFF8001 then 32'h12340000 on consecutive cycles.
- Backpressure: out_ready = 0, send rt = 1, 2, 3 → in_ready falls after the 2nd accept and the 3rd is held off; raise out_ready → outputs rt = 1, 2, 3 in order with no loss.
- Flush with main and skid both full, plus in_valid asserted the same cycle → next cycle out_valid = 0, in_ready = 1; the dropped input never appears.
- ext_op 11, in_imm 16'hABCD → out_imm = 0 and ext_err = 1; ext_err stays 1 across a flush and clears only on rst.
- rst asserted for 1 cycle while skid is full → out_valid = 0, ext_err = 0; in_ready = 1 the cycle after rst deasserts.

Source files
------------

// File: rtl/imm_operand_stage.sv
// Immediate operand stage: selects the zero/sign/LUI operand and
// forwards it to EX through a two-entry skid buffer.
module imm_operand_stage #(
  parameter int DATA_WIDTH_IN  = 16,
  parameter int DATA_WIDTH_OUT = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH_IN-1:0]  in_imm,
  input  logic [DATA_WIDTH_OUT-1:0] in_zext,
  input  logic [DATA_WIDTH_OUT-1:0] in_sext,
  input  logic [1:0]                in_ext_op,
  input  logic [REG_ADDR_WIDTH-1:0] in_rt,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH_OUT-1:0] out_imm,
  output logic [REG_ADDR_WIDTH-1:0] out_rt,
  output logic                      ext_err
);

  localparam int LOW_W = DATA_WIDTH_OUT - DATA_WIDTH_IN;

  logic [DATA_WIDTH_OUT-1:0] sel_imm;
  logic                      sel_bad;

  logic                      main_v, main_v_n;
  logic [DATA_WIDTH_OUT-1:0] main_imm, main_imm_n;
  logic [REG_ADDR_WIDTH-1:0] main_rt, main_rt_n;
  logic                      skid_v, skid_v_n;
  logic [DATA_WIDTH_OUT-1:0] skid_imm, skid_imm_n;
  logic [REG_ADDR_WIDTH-1:0] skid_rt, skid_rt_n;
  logic                      rdy_q;
  logic                      err_q, err_n;
  logic                      accept;
  logic                      pop;

  assign in_ready  = rdy_q;
  assign out_valid = main_v;
  assign out_imm   = main_imm;
  assign out_rt    = main_rt;
  assign ext_err   = err_q;

  assign accept = in_valid && rdy_q;
  assign pop    = main_v && out_ready;

  // Operand select; the illegal encoding yields zero and flags an error.
  always_comb begin
    sel_imm = '0;
    sel_bad = 1'b0;
    unique case (1'b1)
      (in_ext_op == 2'b00): sel_imm = in_zext;
      (in_ext_op == 2'b01): sel_imm = in_sext;
      (in_ext_op == 2'b10): sel_imm = {in_imm, {LOW_W{1'b0}}};
      (in_ext_op == 2'b11): sel_bad = 1'b1;
    endcase
  end

  // Main/skid transfer decisions; flush squashes everything.
  always_comb begin
    main_v_n   = main_v;
    main_imm_n = main_imm;
    main_rt_n  = main_rt;
    skid_v_n   = skid_v;
    skid_imm_n = skid_imm;
    skid_rt_n  = skid_rt;
    err_n      = err_q;
    if (flush) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else begin
      if (accept && sel_bad)
        err_n = 1'b1;
      if (!main_v) begin
        if (accept) begin
          main_v_n   = 1'b1;
          main_imm_n = sel_imm;
          main_rt_n  = in_rt;
        end
      end else if (pop) begin
        if (skid_v) begin
          main_imm_n = skid_imm;
          main_rt_n  = skid_rt;
          skid_v_n   = 1'b0;
        end else if (accept) begin
          main_imm_n = sel_imm;
          main_rt_n  = in_rt;
        end else begin
          main_v_n = 1'b0;
        end
      end else if (accept) begin
        skid_v_n   = 1'b1;
        skid_imm_n = sel_imm;
        skid_rt_n  = in_rt;
      end
    end
  end

  // State registers; in_ready is registered from the next skid state.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v   <= 1'b0;
      main_imm <= '0;
      main_rt  <= '0;
      skid_v   <= 1'b0;
      skid_imm <= '0;
      skid_rt  <= '0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      main_v   <= main_v_n;
      main_imm <= main_imm_n;
      main_rt  <= main_rt_n;
      skid_v   <= skid_v_n;
      skid_imm <= skid_imm_n;
      skid_rt  <= skid_rt_n;
      rdy_q    <= !skid_v_n;
      err_q    <= err_n;
    end
  end

endmodule
